// File: rtl/oled_bar_pixel_gen_if.sv
// oled_bar_pixel_gen_if: frame request and byte-stream handshake between pixel source and SPI controller.
interface oled_bar_pixel_gen_if;
  logic       frame_start_i;
  logic [7:0] y_i;
  logic [7:0] pix_data_o;
  logic       pix_valid_o;
  logic       pix_ready_i;
  logic       busy_o;
  logic       frame_done_o;
  modport master (input frame_start_i, y_i, pix_ready_i, output pix_data_o, pix_valid_o, busy_o, frame_done_o);
  modport slave  (output frame_start_i, y_i, pix_ready_i, input pix_data_o, pix_valid_o, busy_o, frame_done_o);
endinterface

// File: rtl/oled_bar_pixel_gen.sv
// oled_bar_pixel_gen: streams a WIDTH x HEIGHT RGB565 bar-graph frame as bytes, high byte first.
// Define OLED_PIX_GRID_EN to draw dim grey gridlines on background rows where row[2:0]==7.
module oled_bar_pixel_gen #(
  parameter int          WIDTH    = 96,
  parameter int          HEIGHT   = 64,
  parameter int          BAR_X0   = 40,
  parameter int          BAR_W    = 16,
  parameter logic [15:0] FG_COLOR = 16'hF800,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input logic                  clk_i,
  input logic                  rst_i,
  oled_bar_pixel_gen_if.master pix
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_e;
  state_e        state_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    y_lat_q, y_d;
  logic [7:0]    data_q;
  logic          valid_q, busy_q, done_q;
  logic          fire, last_col, last_row;
  logic [15:0]   px_first, px_cur, px_nxt;
  function automatic logic [15:0] colour(input logic [CW-1:0] c, input logic [RW-1:0] r, input logic [7:0] y);
    logic [15:0] bg;
`ifdef OLED_PIX_GRID_EN
    bg = (r[2:0] == 3'b111) ? 16'h2104 : BG_COLOR;
`else
    bg = BG_COLOR;
`endif
    // threshold subtract is 9 bits wide and y is already clamped to HEIGHT, so it never wraps
    return (int'(c) >= BAR_X0 && int'(c) < BAR_X0 + BAR_W && 9'(r) >= 9'(HEIGHT) - {1'b0, y}) ? FG_COLOR : bg;
  endfunction
  always_comb begin
    y_d      = (int'(pix.y_i) >= HEIGHT) ? 8'(HEIGHT) : pix.y_i;
    fire     = valid_q & pix.pix_ready_i;
    last_col = int'(col_q) == WIDTH - 1;
    last_row = int'(row_q) == HEIGHT - 1;
    col_d    = last_col ? '0 : col_q + 1'b1;
    row_d    = last_col ? row_q + 1'b1 : row_q;
    px_first = colour('0, '0, y_d);
    px_cur   = colour(col_q, row_q, y_lat_q);
    px_nxt   = colour(col_d, row_d, y_lat_q);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      y_lat_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (pix.frame_start_i) begin
          state_q <= HI;
          col_q   <= '0;
          row_q   <= '0;
          y_lat_q <= y_d;
          data_q  <= px_first[15:8];
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        HI: if (fire) begin
          state_q <= LO;
          data_q  <= px_cur[7:0];
        end
        LO: if (fire) begin
          if (last_col && last_row) begin
            state_q <= DONE;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= HI;
            col_q   <= col_d;
            row_q   <= row_d;
            data_q  <= px_nxt[15:8];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign pix.pix_data_o   = data_q;
  assign pix.pix_valid_o  = valid_q;
  assign pix.busy_o       = busy_q;
  assign pix.frame_done_o = done_q;
endmodule

// File: tb/tb_oled_bar_pixel_gen.sv
// tb_oled_bar_pixel_gen: scoreboard bench with a per-pixel reference model and random backpressure.
module tb_oled_bar_pixel_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  oled_bar_pixel_gen_if pif();
  oled_bar_pixel_gen dut (.clk_i(clk), .rst_i(rst), .pix(pif));
  typedef struct {logic [7:0] b; bit last;} exp_t;
  exp_t       q[$];
  logic [7:0] cap [0:12287];
  logic [7:0] prev_data;
  int tests = 0, fails = 0, acc_cnt = 0, done_cnt = 0, fidx = 0;
  bit pend = 0, rnd = 0, prev_stall = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] ref_pix(int r, int c, int y);
    int h;
    h = (y > 64) ? 64 : y;
    if (c >= 40 && c < 56 && r >= 64 - h) return 16'hF800;
`ifdef OLED_PIX_GRID_EN
    if (r % 8 == 7) return 16'h2104;
`endif
    return 16'h0000;
  endfunction
  function automatic logic [15:0] cap_pix(int r, int c);
    return {cap[2 * (r * 96 + c)], cap[2 * (r * 96 + c) + 1]};
  endfunction
  task automatic push_frame(int y);
    logic [15:0] p;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 96; c++) begin
        p = ref_pix(r, c, y);
        q.push_back('{b: p[15:8], last: 1'b0});
        q.push_back('{b: p[7:0], last: (r == 63 && c == 95)});
      end
  endtask
  task automatic start(int y, int hold, bit sync);
    if (sync) @(negedge clk);
    pif.y_i = 8'(y);
    pif.frame_start_i = 1'b1;
    push_frame(y);
    repeat (hold) @(negedge clk);
    pif.frame_start_i = 1'b0;
    chk("start_valid", {31'b0, pif.pix_valid_o}, 1);
    chk("start_busy", {31'b0, pif.busy_o}, 1);
  endtask
  task automatic wait_done(int target);
    for (int i = 0; i < 40000 && done_cnt < target; i++) @(negedge clk);
    chk("frame_done_count", done_cnt, target);
    chk("queue_drained", q.size(), 0);
    chk("busy_in_done", {31'b0, pif.busy_o}, 0);
  endtask
  initial begin
    pif.pix_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1 pif.pix_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        fidx = 0;
        pend = 0;
        prev_stall = 0;
      end else begin
        if (pif.frame_done_o || pend) chk("frame_done_pulse", {31'b0, pif.frame_done_o}, {31'b0, pend});
        if (pif.frame_done_o) done_cnt++;
        pend = 0;
        if (prev_stall) chk("hold_stable", {23'b0, pif.pix_valid_o, pif.pix_data_o}, {23'b0, 1'b1, prev_data});
        if (pif.pix_valid_o && pif.pix_ready_i) begin
          acc_cnt++;
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_byte: got %0h expected none", pif.pix_data_o);
          end else begin
            e = q.pop_front();
            chk("byte", pif.pix_data_o, e.b);
            cap[fidx] = pif.pix_data_o;
            fidx = e.last ? 0 : fidx + 1;
            pend = e.last;
          end
        end
        prev_stall = pif.pix_valid_o && !pif.pix_ready_i;
        prev_data = pif.pix_data_o;
      end
    end
  end
  initial begin
    int tgt;
    pif.frame_start_i = 1'b0;
    pif.y_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, pif.pix_valid_o}, 0);
    chk("rst_busy", {31'b0, pif.busy_o}, 0);
    chk("rst_done", {31'b0, pif.frame_done_o}, 0);
    chk("rst_data", pif.pix_data_o, 0);
    #2 rst = 1'b0;
    start(32, 1, 1);
    for (int i = 0; i < 1000 && acc_cnt < 100; i++) @(negedge clk);
    chk("reach_100_bytes", {31'b0, acc_cnt >= 100}, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, pif.pix_valid_o}, 0);
    chk("midrst_busy", {31'b0, pif.busy_o}, 0);
    chk("midrst_data", pif.pix_data_o, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_resume", {31'b0, pif.pix_valid_o}, 0);
    tgt = done_cnt + 1;
    start(32, 1, 1);
    wait_done(tgt);
`ifndef OLED_PIX_GRID_EN
    chk("r31c40", cap_pix(31, 40), 16'h0000);
    chk("r32c40", cap_pix(32, 40), 16'hF800);
    chk("r63c56", cap_pix(63, 56), 16'h0000);
`endif
    tgt = done_cnt + 1;
    start(0, 1, 1);
    wait_done(tgt);
    chk("y0_r63c40", cap_pix(63, 40), 16'h0000);
    tgt = done_cnt + 1;
    start(200, 2, 0);
    wait_done(tgt);
    chk("y200_r0c40", cap_pix(0, 40), 16'hF800);
    chk("y200_r63c55", cap_pix(63, 55), 16'hF800);
    chk("y200_r0c39", cap_pix(0, 39), 16'h0000);
    rnd = 1;
    tgt = done_cnt + 1;
    start(48, 1, 1);
    for (int i = 0; i < 4000 && acc_cnt < 1000; i++) @(negedge clk);
    pif.y_i = 8'd10;
    pif.frame_start_i = 1'b1;
    @(negedge clk);
    pif.frame_start_i = 1'b0;
    wait_done(tgt);
    repeat (20) @(negedge clk);
    chk("single_done", done_cnt, tgt);
    chk("y48_r16c40", cap_pix(16, 40), 16'hF800);
    chk("y48_r15c40", cap_pix(15, 40), 16'h0000);
    rnd = 0;
`ifdef OLED_PIX_GRID_EN
    tgt = done_cnt + 1;
    start(8, 1, 1);
    wait_done(tgt);
    chk("grid_r7c0", cap_pix(7, 0), 16'h2104);
    chk("grid_r63c40", cap_pix(63, 40), 16'hF800);
    chk("grid_r63c0", cap_pix(63, 0), 16'h2104);
    chk("grid_r8c0", cap_pix(8, 0), 16'h0000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
